// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM states, iteration count
// and the RISC-V mandated fast-path quotients.
package div_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PREP,
      CALC,
      FIX,
      DONE
   } state_t;

   localparam int          DIV_ITER  = 32;
   localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
   localparam logic [31:0] OVF_QUOT  = 32'h8000_0000;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring step: shift {rem, dvd} left, trial-subtract the
// divisor magnitude, keep or restore, and shift the quotient bit into dvd.
module div_step #(
   parameter int W = 32
) (
   input  logic [W:0]   rem,
   input  logic [W-1:0] dvd,
   input  logic [W-1:0] dsr,
   output logic [W:0]   rem_next,
   output logic [W-1:0] dvd_next,
   output logic         q_bit
);

   logic [W+1:0] shifted;
   logic [W+1:0] trial;

   // One guard bit above the partial remainder keeps the sign test exact.
   always_comb begin
      shifted  = {rem, dvd[W-1]};
      trial    = shifted - {2'b00, dsr};
      q_bit    = ~trial[W+1];
      rem_next = q_bit ? trial[W:0] : shifted[W:0];
      dvd_next = {dvd[W-2:0], q_bit};
   end

endmodule

// File: rtl/div32.sv
// Iterative signed/unsigned 32-bit divider with start/valid handshake,
// one quotient bit per cycle, and a fast path for /0 and signed overflow.
module div32
   import div_pkg::*;
#(
   parameter int DATA_WIDH = DIV_ITER
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 is_unsigned,
   input  logic                 flush,
   input  logic [DATA_WIDH-1:0] a,
   input  logic [DATA_WIDH-1:0] b,
   output logic                 busy,
   output logic                 valid,
   output logic [DATA_WIDH-1:0] R_quot,
   output logic [DATA_WIDH-1:0] R_rem
);

   localparam int CW = $clog2(DATA_WIDH);

   state_t               state, state_next;
   logic [DATA_WIDH-1:0] a_r, b_r;
   logic                 uns_r;
   logic [DATA_WIDH:0]   rem_q;
   logic [DATA_WIDH-1:0] dvd_q;
   logic [DATA_WIDH-1:0] bmag_q;
   logic                 q_neg, r_neg;
   logic [CW-1:0]        cnt;

   logic [DATA_WIDH:0]   rem_next;
   logic [DATA_WIDH-1:0] dvd_next;
   logic                 q_bit;

   logic                 div0, ovf, a_neg, b_neg, last_iter;
   logic [DATA_WIDH-1:0] a_mag, b_mag;

   // Fast-path decode works on the operands latched at the accepting edge.
   assign div0      = (b_r == '0);
   assign ovf       = !uns_r && (a_r == OVF_QUOT) && (b_r == '1);
   assign a_neg     = !uns_r && a_r[DATA_WIDH-1];
   assign b_neg     = !uns_r && b_r[DATA_WIDH-1];
   assign a_mag     = a_neg ? -a_r : a_r;
   assign b_mag     = b_neg ? -b_r : b_r;
   assign last_iter = (cnt == CW'(DATA_WIDH - 1));

   assign busy  = (state != IDLE);
   assign valid = (state == DONE);

   div_step #(.W(DATA_WIDH)) u_step (
      .rem      (rem_q),
      .dvd      (dvd_q),
      .dsr      (bmag_q),
      .rem_next (rem_next),
      .dvd_next (dvd_next),
      .q_bit    (q_bit)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // NOTE: state_next gets a default first so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (start) state_next = PREP;
         PREP:    state_next = (div0 || ovf) ? DONE : CALC;
         CALC:    if (last_iter) state_next = FIX;
         FIX:     state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (flush) state_next = IDLE;
   end

   // NOTE: datapath registers are small flops, not memories, so all of them
   // take the async reset and a mid-operation reset leaves no stale state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_r    <= '0;
         b_r    <= '0;
         uns_r  <= 1'b0;
         rem_q  <= '0;
         dvd_q  <= '0;
         bmag_q <= '0;
         q_neg  <= 1'b0;
         r_neg  <= 1'b0;
         cnt    <= '0;
         R_quot <= '0;
         R_rem  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start && !flush) begin
                  a_r   <= a;
                  b_r   <= b;
                  uns_r <= is_unsigned;
               end
            end
            PREP: begin
               dvd_q  <= a_mag;
               bmag_q <= b_mag;
               q_neg  <= a_neg ^ b_neg;
               r_neg  <= a_neg;
               rem_q  <= '0;
               cnt    <= '0;
               if (!flush && div0) begin
                  R_quot <= DIV0_QUOT;
                  R_rem  <= a_r;
               end else if (!flush && ovf) begin
                  R_quot <= OVF_QUOT;
                  R_rem  <= '0;
               end
            end
            CALC: begin
               rem_q <= rem_next;
               dvd_q <= dvd_next;
               cnt   <= cnt + 1'b1;
            end
            FIX: begin
               if (!flush) begin
                  R_quot <= q_neg ? -dvd_q : dvd_q;
                  R_rem  <= r_neg ? -rem_q[DATA_WIDH-1:0] : rem_q[DATA_WIDH-1:0];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/div32.md
# div32

Iterative 32-bit integer divider for the RV32M execute stage, the counterpart of the pipelined Booth multiplier. It computes quotient and remainder for DIV/DIVU/REM/REMU using a radix-2 restoring algorithm, one quotient bit per cycle. A start/valid handshake lets the pipeline stall on `busy`. Divide-by-zero and signed overflow are resolved on a one-cycle fast path with RISC-V-mandated results.

## Interface
- `DATA_WIDH`, default 32: operand width; iteration count equals `DATA_WIDH`.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  accept request; sampled only in IDLE.
- `is_unsigned`  in  1  0: signed operands (DIV/REM); 1: unsigned operands (DIVU/REMU).
- `flush`  in  1  synchronous abort from pipeline; highest priority after reset.
- `a`  in  `DATA_WIDH`  dividend; captured at the accepting edge.
- `b`  in  `DATA_WIDH`  divisor; captured at the accepting edge.
- `busy`  out  1  high whenever state is not IDLE.
- `valid`  out  1  single-cycle pulse; results are valid in this cycle.
- `R_quot`  out  `DATA_WIDH`  quotient.
- `R_rem`  out  `DATA_WIDH`  remainder.

## Operation
- **States:**
  - IDLE
  - PREP
  - CALC
  - FIX
  - DONE
- **IDLE + start**, after latching `a`, `b` and `is_unsigned`:
  - If `b == 0`: quotient = all ones; remainder = `a`; go to DONE.
  - Else if signed and `a == 0x80000000` and `b == 0xFFFFFFFF`: quotient = `0x80000000`; remainder = 0; go to DONE.
  - Else: go to PREP.
- **PREP:**
  - Take magnitudes `|a|` and `|b|`; magnitudes are the operands themselves when unsigned.
  - Record `q_neg = a[31] ^ b[31]` and `r_neg = a[31]`; both are 0 when unsigned.
  - Clear the 33-bit partial remainder and the iteration counter; go to CALC.
- **CALC**, one step per cycle:
  - Shift `{rem, dvd}` left by 1.
  - Trial subtract: `rem - |b|` (33-bit).
  - If the result is non-negative, keep it and set quotient bit 1; otherwise restore and set quotient bit 0.
  - Counter runs 0..31; at count 31, go to FIX.
- **FIX:** negate the quotient if `q_neg`; negate the remainder if `r_neg`; go to DONE.
- **DONE:** `valid = 1` for exactly one cycle; next state IDLE.
- **Result rules:**
  - Remainder sign follows the dividend.
  - Quotient truncates toward zero.
  - Remainder satisfies `a = q*b + r`.
- `R_quot` and `R_rem` are registered and update only on entry to DONE; they hold until the next DONE.
- `start` while `busy` (including in DONE) is ignored and never queued.
- **`flush`** in any state: next state IDLE, no `valid`, outputs unchanged. `flush` together with `start` in IDLE: request dropped.

## Timing
- **Reset values:**
  - state IDLE
  - `busy = 0`
  - `valid = 0`
  - `R_quot = 0`
  - `R_rem = 0`
  - internal registers 0
- **Reset mid-operation:** immediate abort to these values.
- **Normal latency:** start sampled at edge 0; `valid` high in the cycle following edge 34. Sequence is PREP, then 32 CALC cycles, then FIX.
- **Fast path latency:** `valid` high in the cycle following edge 1.
- `busy` rises after the accepting edge and falls on the edge that ends DONE.
- **Back-to-back:** a new start is accepted earliest in the cycle after DONE.
- Operand changes after the accepting edge do not affect the result.

## Structure
- **Shared package `div_pkg`:**
  - state enum (IDLE, PREP, CALC, FIX, DONE)
  - `DIV_ITER = 32`
  - constants `DIV0_QUOT = 32'hFFFF_FFFF` and `OVF_QUOT = 32'h8000_0000`
- **Sub-module `div_step`:** combinational shift/trial-subtract/restore on `{rem[32:0], dvd[31:0]}` and `|b|`; outputs the next `rem`, next `dvd` and the quotient bit. Instantiated once in CALC.
- Control FSM, counter, sign fix-up and output registers stay in `div32`.

## Test plan
- Signed 100 / 7 → `R_quot = 14`, `R_rem = 2`, `valid` pulses once 34 cycles after start; `busy` high throughout.
- Signed −7 / 2 (`0xFFFFFFF9`, 2) → `R_quot = 0xFFFFFFFD`, `R_rem = 0xFFFFFFFF`. Unsigned `0xFFFFFFFF` / 1 → `R_quot = 0xFFFFFFFF`, `R_rem = 0`.
- Divide by zero, signed 5 / 0 → `R_quot = 0xFFFFFFFF`, `R_rem = 5`, latency 1. Overflow, signed `0x80000000` / `0xFFFFFFFF` → `R_quot = 0x80000000`, `R_rem = 0`, latency 1. Unsigned `0x80000000` / `0xFFFFFFFF` → normal path: `R_quot = 0`, `R_rem = 0x80000000`.
- Start 20 / 3; pulse `start` with 9 / 9 at cycle 10 → second start ignored; result `R_quot = 6`, `R_rem = 2`; no second `valid`.
- Start 50 / 5 and assert `flush` at cycle 12 → no `valid`, `busy` low next cycle, outputs keep prior values. Restart 50 / 5 → `R_quot = 10`, `R_rem = 0`.
- Assert `rst` at cycle 20 of an operation → outputs 0, `busy = 0` asynchronously. After release, a new 9 / 4 → `R_quot = 2`, `R_rem = 1`.
